// File: rtl/akarin_arb_pkg.sv
// Shared types and helpers for the akarin memory-bus arbiter.
//   arb_state_e : two-state transaction FSM (idle / one access in flight)
//   PRIO_RR     : round-robin grant policy selector value
//   PRIO_FIXED  : fixed-priority (lowest index wins) selector value
//   owner_w()   : width of a channel index, never less than one bit
package akarin_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  function automatic int owner_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/akarin_rr_picker.sv
// Combinational rotating picker: searches the request vector starting at
// index `start`, wrapping at NCH, and reports the first asserted channel.
// Ports:
//   req     in  [NCH-1:0] request vector
//   start   in  [OW-1:0]  index searched first (must be < NCH)
//   gnt_vld out           some request is asserted
//   gnt_idx out [OW-1:0]  winning channel index
module akarin_rr_picker #(
  parameter int NCH = 2,
  parameter int OW  = 1
) (
  input  logic [NCH-1:0] req,
  input  logic [OW-1:0]  start,
  output logic           gnt_vld,
  output logic [OW-1:0]  gnt_idx
);

  logic [NCH-1:0] rot;
  logic [OW:0]    sum;

  always_comb begin
    // Rotating a doubled copy puts channel `start` at bit 0 so a plain
    // lowest-bit search implements the wrap-around order.
    rot     = NCH'({req, req} >> start);
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int j = 0; j < NCH; j++) begin
      if (!gnt_vld && rot[j]) begin
        gnt_vld = 1'b1;
        sum     = {1'b0, start} + (OW+1)'(j);
        if (sum >= (OW+1)'(NCH)) sum = sum - (OW+1)'(NCH);
        gnt_idx = sum[OW-1:0];
      end
    end
  end

endmodule

// File: rtl/akarin_bus_arbiter.sv
// N-channel memory-bus arbiter: merges NCH core-side masters onto a single
// memory port with exactly one transaction in flight. Grant policy is
// round-robin (PRIO_MODE=0) or fixed lowest-index priority (PRIO_MODE=1).
// Optional feature macro: AKARIN_ARB_TIMEOUT_EN -- aborts an access with an
// error strobe after TIMEOUT busy cycles without mem_ack.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   ch_req/we/addr/wdata/be  packed per-channel request fields
//   ch_ack, ch_err           one-hot completion / error strobe to the owner
//   ch_rdata                 shared read data (mem_rdata pass-through)
//   mem_req/we/addr/wdata/be registered memory-side request
//   mem_ack, mem_rdata       memory completion strobe and read data
module akarin_bus_arbiter
  import akarin_arb_pkg::*;
#(
  parameter int NCH       = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NCH-1:0]      ch_req,
  input  logic [NCH-1:0]      ch_we,
  input  logic [NCH*AW-1:0]   ch_addr,
  input  logic [NCH*DW-1:0]   ch_wdata,
  input  logic [NCH*DW/8-1:0] ch_be,
  output logic [NCH-1:0]      ch_ack,
  output logic [NCH-1:0]      ch_err,
  output logic [DW-1:0]       ch_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [DW/8-1:0]     mem_be,
  input  logic                mem_ack,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int OW = owner_w(NCH);
  localparam int BW = DW / 8;

  arb_state_e     state, state_nxt;
  logic [OW-1:0]  ptr, owner;
  logic [OW-1:0]  pick_start, pick_idx;
  logic           pick_vld;
  logic           grant, done, tmo;
  logic [NCH-1:0] own_oh;

  assign pick_start = (PRIO_MODE == PRIO_FIXED) ? '0 : ptr;

  akarin_rr_picker #(.NCH(NCH), .OW(OW)) u_picker (
    .req     (ch_req),
    .start   (pick_start),
    .gnt_vld (pick_vld),
    .gnt_idx (pick_idx)
  );

  assign grant  = (state == ARB_IDLE) && pick_vld;
  assign own_oh = NCH'(1) << owner;

`ifdef AKARIN_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt;

  // Counter holds zero while idle, so the first busy cycle sees 0 and the
  // abort lands in busy cycle number TIMEOUT. A real ack in that cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                    tcnt <= '0;
    else if (state == ARB_IDLE)  tcnt <= '0;
    else                         tcnt <= tcnt + TW'(1);
  end

  assign tmo = (state == ARB_BUSY) && !mem_ack && (tcnt == TW'(TIMEOUT - 1));
`else
  assign tmo = 1'b0;
`endif

  assign done = (state == ARB_BUSY) && (mem_ack || tmo);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ARB_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE: if (pick_vld) state_nxt = ARB_BUSY;
      ARB_BUSY: if (done)     state_nxt = ARB_IDLE;
      default:                state_nxt = ARB_IDLE;
    endcase
  end

  // Winner's fields are captured on grant and held for the whole access;
  // requests arriving while busy never touch these registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= '0;
      ptr       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (grant) begin
      owner     <= pick_idx;
      ptr       <= (pick_idx == OW'(NCH - 1)) ? '0 : pick_idx + OW'(1);
      mem_we    <= ch_we[pick_idx];
      mem_addr  <= ch_addr[pick_idx*AW +: AW];
      mem_wdata <= ch_wdata[pick_idx*DW +: DW];
      mem_be    <= ch_be[pick_idx*BW +: BW];
    end
  end

  // Outputs
  always_comb begin
    mem_req  = (state == ARB_BUSY);
    ch_ack   = done ? own_oh : '0;
    ch_err   = tmo  ? own_oh : '0;
    ch_rdata = tmo  ? '0     : mem_rdata;
  end

endmodule

// File: tb/tb_akarin_bus_arbiter.sv
module tb_akarin_bus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int TMO = 8;
  localparam int NA  = 3;
  localparam int NB  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NA-1:0]    a_req, a_we, a_ack, a_err;
  logic [NA*AW-1:0] a_addr;
  logic [NA*DW-1:0] a_wdata;
  logic [NA*BW-1:0] a_be;
  logic [DW-1:0]    a_rdata, a_mwdata, a_mrdata;
  logic [AW-1:0]    a_maddr;
  logic [BW-1:0]    a_mbe;
  logic             a_mreq, a_mwe, a_mack;

  logic [NB-1:0]    b_req, b_we, b_ack, b_err;
  logic [NB*AW-1:0] b_addr;
  logic [NB*DW-1:0] b_wdata;
  logic [NB*BW-1:0] b_be;
  logic [DW-1:0]    b_rdata, b_mwdata, b_mrdata;
  logic [AW-1:0]    b_maddr;
  logic [BW-1:0]    b_mbe;
  logic             b_mreq, b_mwe, b_mack;

  akarin_bus_arbiter #(.NCH(NA), .AW(AW), .DW(DW), .PRIO_MODE(0), .TIMEOUT(TMO)) dut_rr (
    .clk(clk), .rst(rst),
    .ch_req(a_req), .ch_we(a_we), .ch_addr(a_addr), .ch_wdata(a_wdata), .ch_be(a_be),
    .ch_ack(a_ack), .ch_err(a_err), .ch_rdata(a_rdata),
    .mem_req(a_mreq), .mem_we(a_mwe), .mem_addr(a_maddr), .mem_wdata(a_mwdata),
    .mem_be(a_mbe), .mem_ack(a_mack), .mem_rdata(a_mrdata)
  );

  akarin_bus_arbiter #(.NCH(NB), .AW(AW), .DW(DW), .PRIO_MODE(1), .TIMEOUT(TMO)) dut_fix (
    .clk(clk), .rst(rst),
    .ch_req(b_req), .ch_we(b_we), .ch_addr(b_addr), .ch_wdata(b_wdata), .ch_be(b_be),
    .ch_ack(b_ack), .ch_err(b_err), .ch_rdata(b_rdata),
    .mem_req(b_mreq), .mem_we(b_mwe), .mem_addr(b_maddr), .mem_wdata(b_mwdata),
    .mem_be(b_mbe), .mem_ack(b_mack), .mem_rdata(b_mrdata)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0;
    a_mack = 1'b0; a_mrdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0;
    b_mack = 1'b0; b_mrdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  task automatic a_drive(input int c, input logic r, input logic w, input logic [AW-1:0] ad,
                         input logic [DW-1:0] wd, input logic [BW-1:0] be);
    a_req[c] = r;
    a_we[c]  = w;
    a_addr[c*AW +: AW]  = ad;
    a_wdata[c*DW +: DW] = wd;
    a_be[c*BW +: BW]    = be;
  endtask

  task automatic b_drive(input int c, input logic r, input logic [AW-1:0] ad);
    b_req[c] = r;
    b_we[c]  = 1'b0;
    b_addr[c*AW +: AW]  = ad;
    b_wdata[c*DW +: DW] = '0;
    b_be[c*BW +: BW]    = 4'hF;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    a_req = 3'b111;
    b_req = 2'b11;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({a_mreq, a_mwe, a_maddr, a_mwdata, a_mbe} !== '0) begin
      n_fail++;
      $display("FAIL reset_rr_mem: got %h want 0", {a_mreq, a_mwe, a_maddr, a_mwdata, a_mbe});
    end
    n_chk++;
    if ({a_ack, a_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_rr_ack: got %b want 0", {a_ack, a_err});
    end
    n_chk++;
    if ({b_mreq, b_mwe, b_maddr, b_mwdata, b_mbe, b_ack, b_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_fix_all: got %h want 0", {b_mreq, b_mwe, b_maddr, b_mwdata, b_mbe, b_ack, b_err});
    end
    clear_inputs();
    rst = 1'b1;
    tick();
    @(negedge clk);
    n_chk++;
    if (a_mreq !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle_after: got %b want 0", a_mreq);
    end
  endtask

  task automatic test_single_read();
    do_reset();
    a_drive(0, 1'b1, 1'b0, 32'h100, '0, 4'hF);
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL rd_cycle0: got %b want 0000", {a_mreq, a_ack});
    end
    tick();
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_mwe, a_maddr} !== {1'b1, 1'b0, 32'h100}) begin
      n_fail++;
      $display("FAIL rd_cycle1_mem: got %h want %h", {a_mreq, a_mwe, a_maddr}, {1'b1, 1'b0, 32'h100});
    end
    tick();
    a_mack = 1'b1;
    a_mrdata = 32'hDEADBEEF;
    @(negedge clk);
    n_chk++;
    if (a_ack !== 3'b001 || a_err !== 3'b000 || a_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL rd_cycle2_ack: got ack=%b err=%b rdata=%h want 001 000 deadbeef", a_ack, a_err, a_rdata);
    end
    tick();
    a_mack = 1'b0;
    a_req = '0;
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL rd_cycle3_idle: got %b want 0000", {a_mreq, a_ack});
    end
  endtask

  task automatic test_write_be();
    do_reset();
    a_drive(1, 1'b1, 1'b1, 32'h2004, 32'h12345678, 4'b0011);
    @(negedge clk);
    for (int b = 1; b <= 3; b++) begin
      tick();
      if (b == 1) a_drive(2, 1'b1, 1'b0, 32'h3000, 32'hFFFFFFFF, 4'hF);
      @(negedge clk);
      n_chk++;
      if ({a_mreq, a_mwe, a_mbe, a_maddr, a_mwdata} !== {1'b1, 1'b1, 4'b0011, 32'h2004, 32'h12345678}) begin
        n_fail++;
        $display("FAIL wr_hold_%0d: got %h want %h", b, {a_mreq, a_mwe, a_mbe, a_maddr, a_mwdata},
                 {1'b1, 1'b1, 4'b0011, 32'h2004, 32'h12345678});
      end
    end
    tick();
    a_req[2] = 1'b0;
    a_mack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_ack !== 3'b010 || a_err !== 3'b000) begin
      n_fail++;
      $display("FAIL wr_ack: got ack=%b err=%b want 010 000", a_ack, a_err);
    end
    tick();
    a_mack = 1'b0;
    a_req = '0;
    @(negedge clk);
    n_chk++;
    if (a_mreq !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_release: got %b want 0", a_mreq);
    end
  endtask

  task automatic test_rr_contention();
    int got[$];
    int when[$];
    bit pm, pa;
    pm = 1'b0;
    pa = 1'b0;
    do_reset();
    a_drive(0, 1'b1, 1'b0, 32'h1000, '0, 4'hF);
    a_drive(1, 1'b1, 1'b0, 32'h1100, '0, 4'hF);
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      a_mack = pm && !pa;
      a_mrdata = 32'hA000 + cyc;
      @(negedge clk);
      pm = a_mreq;
      pa = a_mack;
      if (a_ack != '0) begin
        n_chk++;
        if (!$onehot(a_ack) || a_rdata !== a_mrdata) begin
          n_fail++;
          $display("FAIL rr_ack_shape: got ack=%b rdata=%h want onehot rdata=%h", a_ack, a_rdata, a_mrdata);
        end
        got.push_back($clog2(a_ack));
        when.push_back(cyc);
      end
      tick();
    end
    a_req = '0;
    a_mack = 1'b0;
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL rr_count: got %0d acks want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got[k] != (k % 2)) begin
          n_fail++;
          $display("FAIL rr_order_%0d: got ch%0d want ch%0d", k, got[k], k % 2);
        end
      end
      n_chk++;
      if (when[0] != 2 || when[1] - when[0] != 3 || when[3] - when[2] != 3) begin
        n_fail++;
        $display("FAIL rr_timing: got cycles %0d %0d %0d %0d want 2 5 8 11", when[0], when[1], when[2], when[3]);
      end
    end
  endtask

  task automatic test_fixed_prio();
    int got[$];
    bit pm, pa;
    pm = 1'b0;
    pa = 1'b0;
    do_reset();
    b_drive(0, 1'b1, 32'h10);
    b_drive(1, 1'b1, 32'h20);
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      b_mack = pm && !pa;
      b_mrdata = 32'hB000 + cyc;
      @(negedge clk);
      pm = b_mreq;
      pa = b_mack;
      if (b_ack != '0) got.push_back($clog2(b_ack));
      tick();
      if (got.size() == 3) b_req[0] = 1'b0;
    end
    b_req = '0;
    b_mack = 1'b0;
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL fix_count: got %0d acks want 4", got.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_chk++;
        if (got[k] != ((k == 3) ? 1 : 0)) begin
          n_fail++;
          $display("FAIL fix_order_%0d: got ch%0d want ch%0d", k, got[k], (k == 3) ? 1 : 0);
        end
      end
    end
  endtask

  task automatic test_timeout();
`ifdef AKARIN_ARB_TIMEOUT_EN
    do_reset();
    a_drive(2, 1'b1, 1'b0, 32'h300, '0, 4'hF);
    a_mrdata = 32'hCAFEF00D;
    @(negedge clk);
    for (int b = 1; b <= TMO; b++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if (b < TMO) begin
        if ({a_mreq, a_ack, a_err} !== 7'b1000000) begin
          n_fail++;
          $display("FAIL tmo_wait_%0d: got %b want 1000000", b, {a_mreq, a_ack, a_err});
        end
      end else begin
        if (a_ack !== 3'b100 || a_err !== 3'b100 || a_rdata !== '0) begin
          n_fail++;
          $display("FAIL tmo_fire: got ack=%b err=%b rdata=%h want 100 100 0", a_ack, a_err, a_rdata);
        end
      end
    end
    tick();
    a_req = '0;
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_ack, a_err} !== 7'b0) begin
      n_fail++;
      $display("FAIL tmo_idle: got %b want 0000000", {a_mreq, a_ack, a_err});
    end
    do_reset();
    a_drive(0, 1'b1, 1'b0, 32'h310, '0, 4'hF);
    a_mrdata = 32'hCAFEF00D;
    @(negedge clk);
    for (int b = 1; b <= TMO; b++) begin
      tick();
      if (b == TMO) a_mack = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (a_ack !== 3'b001 || a_err !== 3'b000 || a_rdata !== 32'hCAFEF00D) begin
      n_fail++;
      $display("FAIL tmo_ack_wins: got ack=%b err=%b rdata=%h want 001 000 cafef00d", a_ack, a_err, a_rdata);
    end
    tick();
    a_mack = 1'b0;
    a_req = '0;
`else
    do_reset();
    a_drive(2, 1'b1, 1'b0, 32'h300, '0, 4'hF);
    a_mrdata = 32'hCAFEF00D;
    @(negedge clk);
    for (int b = 1; b <= 20; b++) begin
      tick();
      @(negedge clk);
      n_chk++;
      if ({a_mreq, a_ack, a_err} !== 7'b1000000) begin
        n_fail++;
        $display("FAIL notmo_hold_%0d: got %b want 1000000", b, {a_mreq, a_ack, a_err});
      end
    end
    a_req = '0;
`endif
  endtask

  task automatic test_reset_midop();
    do_reset();
    a_drive(1, 1'b1, 1'b0, 32'h4000, '0, 4'hF);
    tick();
    tick();
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_maddr} !== {1'b1, 32'h4000}) begin
      n_fail++;
      $display("FAIL midop_busy: got %h want %h", {a_mreq, a_maddr}, {1'b1, 32'h4000});
    end
    #2 rst = 1'b0;
    #1;
    n_chk++;
    if ({a_mreq, a_ack, a_maddr} !== '0) begin
      n_fail++;
      $display("FAIL midop_async_drop: got %h want 0", {a_mreq, a_ack, a_maddr});
    end
    a_req = '0;
    @(negedge clk);
    rst = 1'b1;
    tick();
    a_mack = 1'b1;
    a_mrdata = 32'h5555;
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_ack} !== 4'b0) begin
      n_fail++;
      $display("FAIL midop_late_ack: got %b want 0000", {a_mreq, a_ack});
    end
    tick();
    a_mack = 1'b0;
    a_drive(1, 1'b1, 1'b0, 32'h4100, '0, 4'hF);
    a_drive(2, 1'b1, 1'b0, 32'h4200, '0, 4'hF);
    tick();
    @(negedge clk);
    n_chk++;
    if ({a_mreq, a_maddr} !== {1'b1, 32'h4100}) begin
      n_fail++;
      $display("FAIL midop_ptr0: got %h want %h", {a_mreq, a_maddr}, {1'b1, 32'h4100});
    end
    tick();
    a_mack = 1'b1;
    @(negedge clk);
    n_chk++;
    if (a_ack !== 3'b010) begin
      n_fail++;
      $display("FAIL midop_ack: got %b want 010", a_ack);
    end
    tick();
    a_mack = 1'b0;
    a_req = '0;
  endtask

  // Reference model: channels hold requests until acked, a memory with random
  // 1..3 cycle latency, and round-robin choice among pending channels.
  task automatic test_random();
    bit            pend[NA];
    logic          we_m[NA];
    logic [AW-1:0] ad_m[NA];
    logic [DW-1:0] wd_m[NA];
    logic [BW-1:0] be_m[NA];
    logic [NA-1:0] exp_ack;
    bit busy;
    int owner, ptr, wl, nacks, cc;
    busy = 1'b0; owner = 0; ptr = 0; wl = 0; nacks = 0;
    for (int c = 0; c < NA; c++) begin
      pend[c] = 1'b0; we_m[c] = 1'b0; ad_m[c] = '0; wd_m[c] = '0; be_m[c] = '0;
    end
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < NA; c++) a_drive(c, pend[c], we_m[c], ad_m[c], wd_m[c], be_m[c]);
      a_mack = busy ? (wl == 0) : ($urandom_range(0, 5) == 0);
      a_mrdata = $urandom;
      @(negedge clk);
      exp_ack = (busy && a_mack) ? (NA'(1) << owner) : '0;
      n_chk++;
      if (a_mreq !== busy) begin
        n_fail++;
        $display("FAIL rand_mem_req cyc%0d: got %b want %b", cyc, a_mreq, busy);
      end
      if (busy) begin
        n_chk++;
        if ({a_mwe, a_maddr, a_mwdata, a_mbe} !== {we_m[owner], ad_m[owner], wd_m[owner], be_m[owner]}) begin
          n_fail++;
          $display("FAIL rand_fields cyc%0d: got %h want %h", cyc, {a_mwe, a_maddr, a_mwdata, a_mbe},
                   {we_m[owner], ad_m[owner], wd_m[owner], be_m[owner]});
        end
      end
      n_chk++;
      if (a_ack !== exp_ack || a_err !== '0) begin
        n_fail++;
        $display("FAIL rand_ack cyc%0d: got ack=%b err=%b want %b 000", cyc, a_ack, a_err, exp_ack);
      end
      if (exp_ack != '0) begin
        n_chk++;
        if (a_rdata !== a_mrdata) begin
          n_fail++;
          $display("FAIL rand_rdata cyc%0d: got %h want %h", cyc, a_rdata, a_mrdata);
        end
      end
      if (busy) begin
        if (a_mack) begin
          busy = 1'b0;
          pend[owner] = 1'b0;
          nacks++;
        end else begin
          wl--;
          if ($urandom_range(0, 15) == 0) pend[owner] = 1'b0;
        end
      end else begin
        for (int k = 0; k < NA; k++) begin
          cc = (ptr + k) % NA;
          if (!busy && pend[cc]) begin
            busy = 1'b1;
            owner = cc;
            ptr = (cc + 1) % NA;
            wl = $urandom_range(1, 3);
          end
        end
      end
      for (int c = 0; c < NA; c++) begin
        if (!pend[c] && !(busy && c == owner) && $urandom_range(0, 2) == 0) begin
          pend[c] = 1'b1;
          we_m[c] = 1'($urandom_range(0, 1));
          ad_m[c] = $urandom;
          wd_m[c] = $urandom;
          be_m[c] = 4'($urandom_range(0, 15));
        end
      end
      tick();
    end
    a_req = '0;
    a_mack = 1'b0;
    n_chk++;
    if (nacks < 50) begin
      n_fail++;
      $display("FAIL rand_progress: got %0d completions want at least 50", nacks);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_write_be();
    test_rr_contention();
    test_fixed_prio();
    test_timeout();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/akarin_bus_arbiter.md
Name: akarin_bus_arbiter

Overview:
- Parametrised N-channel memory-bus arbiter. Merges NCH core-side masters (instruction fetch, data, future DMA/debug) onto one shared memory port.
- Lets a pipeline with split instruction/data buses run against a single unified memory.
- Exactly one transaction outstanding at a time.
- Grant policy selectable: round-robin or fixed priority.

Parameters:
NCH, 2, number of requesting channels (1..8); channel 0 = instruction fetch by convention
AW, 32, address width
DW, 32, data width (multiple of 8)
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins)
TIMEOUT, 64, cycles to wait for mem_ack before abort (used only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ch_req  in  NCH  per-channel request; held high until ch_ack
ch_we  in  NCH  per-channel write enable
ch_addr  in  NCH*AW  per-channel address, packed, channel i at [i*AW +: AW]
ch_wdata  in  NCH*DW  per-channel write data, packed
ch_be  in  NCH*DW/8  per-channel byte enables, packed
ch_ack  out  NCH  one-hot completion strobe to the owning channel
ch_err  out  NCH  error strobe, coincident with ch_ack
ch_rdata  out  DW  read data, shared by all channels, valid only with ch_ack
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_be  out  DW/8  memory byte enables
mem_ack  in  1  memory completion, one-cycle strobe, any latency >= 1 cycle after mem_req
mem_rdata  in  DW  memory read data, valid with mem_ack

Behaviour:
- Reset (rst low, async): state IDLE, mem_req = 0, mem_we/addr/wdata/be = 0, RR pointer = 0, owner = 0, timeout counter = 0. Reset mid-transaction drops mem_req immediately; the in-flight access is abandoned and no ch_ack is issued. The memory must ignore a late mem_ack after reset.
- FSM, IDLE -> BUSY: any ch_req high. The winner is picked combinationally and its fields are registered into mem_*. mem_req = 1 from the next cycle. Owner index is latched.
- FSM, BUSY: mem_* held stable. Further requests are ignored.
- FSM, BUSY -> IDLE: on mem_ack. In the same cycle:
  - ch_ack[owner] = 1 and ch_rdata = mem_rdata (combinational pass-through).
  - mem_req falls at the next edge.
- Latency: requester sees ch_ack at the earliest 2 cycles after raising ch_req (1-cycle memory). There is one forced IDLE cycle between transactions, so peak throughput is 1 transaction / 3 cycles with 1-cycle memory.
- Round-robin: after a grant to channel i, the pointer becomes (i+1) mod NCH. Search starts at the pointer and wraps.
- Fixed priority: pointer unused; lowest asserted index wins. Starvation of higher indices is allowed.
- Channel rule: a channel keeps ch_req and its fields stable until ch_ack. It may keep ch_req high after ack for a back-to-back request, which then re-arbitrates normally.
- If a channel drops ch_req while owned, the transaction still completes and ch_ack still pulses.
- mem_ack while IDLE is ignored.
- ch_ack, ch_err outside completion cycles: 0.
- ch_rdata outside ack cycles: don't-care (drive mem_rdata).
- NCH = 1 degenerates to a registered pass-through with the same latency.

Optional Feature:
- Macro: AKARIN_ARB_TIMEOUT_EN.
- Enabled:
  - A counter runs in BUSY, cleared on entry.
  - If it reaches TIMEOUT without mem_ack: ch_ack[owner] = 1 and ch_err[owner] = 1 for one cycle, ch_rdata = 0, mem_req drops, FSM returns to IDLE.
  - A simultaneous mem_ack in the timeout cycle wins (normal completion, no error).
- Disabled: no counter logic; ch_err tied to 0; BUSY waits indefinitely.

Decomposition:
- Package akarin_arb_pkg:
  - enum arb_state_e {ARB_IDLE, ARB_BUSY}
  - localparams PRIO_RR = 0, PRIO_FIXED = 1
  - function clog2-safe owner width, $clog2(NCH) with a minimum of 1
- Sub-module akarin_rr_picker (combinational): inputs req vector and start pointer; outputs grant-valid and grant index. Instantiated once; PRIO_MODE = 1 drives pointer 0.

Test Plan:
- Single read: ch0 reads 0x100, memory acks 1 cycle after mem_req with 0xDEADBEEF -> ch_ack = 2'b01 at cycle 2 from ch_req, ch_rdata = 0xDEADBEEF, mem_req low at cycle 3.
- RR contention: PRIO_MODE = 0, ch0 and ch1 both request continuously -> grants alternate 0,1,0,1 over 4 transactions; each ack is one-hot to the correct owner.
- Fixed priority: PRIO_MODE = 1, ch0 requests back-to-back, ch1 held -> ch1 not granted until ch0 drops ch_req, then granted next IDLE.
- Write with byte enables: ch1 writes 0x12345678, ch_be = 4'b0011, addr 0x2004 -> mem_we = 1, mem_be = 4'b0011, mem_addr = 0x2004 stable until mem_ack.
- Timeout (macro on, TIMEOUT = 8): memory never acks -> at BUSY cycle 8: ch_ack[owner] = 1, ch_err[owner] = 1, ch_rdata = 0, then IDLE. Macro off: mem_req stays high.
- Reset mid-op: assert rst low while BUSY with mem_req = 1 -> mem_req = 0 immediately, no ch_ack. After release, a new ch1 request is granted starting from pointer 0.
